bck_slot_scheduler: RTL and testbench

//  Issues backward-extension tokens into the CONTROL_STAGE1 pipeline, sharing it among up to
//  2**SLOT_W reads in flight. Admits reads, issues one BCK_INI then repeated BCK_RUN tokens per

---
 rtl/bck_slot_scheduler.sv | 124 ++++++++++++
 tb/tb_bck_slot_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bck_slot_scheduler.sv
// Backward-extension token scheduler: shares the stage-1 pipeline among up to 2**SLOT_W reads,
// issuing one BCK_INI then BCK_RUN tokens per read round-robin, retiring on last_one_read.
module bck_slot_scheduler #(
  parameter int unsigned SLOT_W         = 2,
  parameter int unsigned READ_NUM_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      req_valid,
  input  logic [READ_NUM_WIDTH-1:0] req_read_num,
  output logic                      req_ready,
  output logic [5:0]                issue_status,
  output logic [SLOT_W-1:0]         issue_slot,
  output logic [READ_NUM_WIDTH-1:0] issue_read,
  input  logic                      ret_valid,
  input  logic [SLOT_W-1:0]         ret_slot,
  input  logic                      ret_last,
  output logic                      done_valid,
  output logic [READ_NUM_WIDTH-1:0] done_read,
  output logic                      busy
);

  localparam int unsigned NSLOT   = 1 << SLOT_W;
  localparam logic [5:0]  ST_INI  = 6'b00_1000;
  localparam logic [5:0]  ST_RUN  = 6'b01_0000;
  localparam logic [5:0]  ST_BUB  = 6'b00_0000;

  typedef enum logic [1:0] {
    S_FREE,
    S_PEND,
    S_FLY,
    S_RDY
  } slot_state_e;

  slot_state_e               state_q [NSLOT];
  logic [READ_NUM_WIDTH-1:0] id_q    [NSLOT];
  logic [SLOT_W-1:0]         rr_q;

  logic              free_found;
  logic [SLOT_W-1:0] free_idx;
  logic              pick_found;
  logic [SLOT_W-1:0] pick_idx;
  logic [SLOT_W-1:0] scan_idx;
  logic              ret_hit;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    busy       = 1'b0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (state_q[i] != S_FREE) begin
        busy = 1'b1;
      end else if (!free_found) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
    req_ready = free_found;
  end

  // Scan starts at the round-robin pointer; SLOT_W-bit addition wraps modulo slot count.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < NSLOT; k++) begin
      scan_idx = rr_q + SLOT_W'(k);
      if (!pick_found && (state_q[scan_idx] == S_PEND || state_q[scan_idx] == S_RDY)) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign ret_hit = ret_valid && (state_q[ret_slot] == S_FLY);

  // Admission targets a FREE slot, issue a PEND/RDY slot, return a FLY slot: never the same one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NSLOT; i++) begin
        state_q[i] <= S_FREE;
        id_q[i]    <= '0;
      end
      rr_q         <= '0;
      issue_status <= ST_BUB;
      issue_slot   <= '0;
      issue_read   <= '0;
      done_valid   <= 1'b0;
      done_read    <= '0;
    end else begin
      if (req_valid && free_found) begin
        state_q[free_idx] <= S_PEND;
        id_q[free_idx]    <= req_read_num;
      end
      if (stall) begin
        done_valid <= 1'b0;
      end else begin
        if (pick_found) begin
          state_q[pick_idx] <= S_FLY;
          issue_status      <= (state_q[pick_idx] == S_PEND) ? ST_INI : ST_RUN;
          issue_slot        <= pick_idx;
          issue_read        <= id_q[pick_idx];
          rr_q              <= pick_idx + 1'b1;
        end else begin
          issue_status <= ST_BUB;
          issue_slot   <= '0;
          issue_read   <= '0;
        end
        if (ret_hit && ret_last) begin
          state_q[ret_slot] <= S_FREE;
          done_valid        <= 1'b1;
          done_read         <= id_q[ret_slot];
        end else begin
          done_valid <= 1'b0;
          if (ret_hit) begin
            state_q[ret_slot] <= S_RDY;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bck_slot_scheduler.sv
// Scoreboard bench for bck_slot_scheduler: a slot-table reference model predicts issued tokens
// and retirements into queues; a monitor pops and compares them as the DUT presents them.
module tb_bck_slot_scheduler;
  localparam int NS = 4;
  localparam logic [5:0] INI = 6'b00_1000;
  localparam logic [5:0] RUN = 6'b01_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stall = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_read_num = '0;
  logic       req_ready;
  logic [5:0] issue_status;
  logic [1:0] issue_slot;
  logic [7:0] issue_read;
  logic       ret_valid = 1'b0;
  logic [1:0] ret_slot = '0;
  logic       ret_last = 1'b0;
  logic       done_valid;
  logic [7:0] done_read;
  logic       busy;

  always #5 clk = ~clk;

  bck_slot_scheduler #(.SLOT_W(2), .READ_NUM_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req_valid(req_valid), .req_read_num(req_read_num), .req_ready(req_ready),
    .issue_status(issue_status), .issue_slot(issue_slot), .issue_read(issue_read),
    .ret_valid(ret_valid), .ret_slot(ret_slot), .ret_last(ret_last),
    .done_valid(done_valid), .done_read(done_read), .busy(busy)
  );

  typedef struct packed {
    logic [5:0] st;
    logic [1:0] slot;
    logic [7:0] rd;
  } iss_t;

  iss_t       iss_q[$];
  logic [7:0] done_q[$];
  int vectors = 0;
  int errors  = 0;

  // Reference model: occupancy, token-outstanding and already-started flags per slot.
  bit         m_used[NS];
  bit         m_out[NS];
  bit         m_started[NS];
  logic [7:0] m_id[NS];
  int         m_rr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_any_used();
    for (int i = 0; i < NS; i++) if (m_used[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_any_free();
    for (int i = 0; i < NS; i++) if (!m_used[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] pick_ret_slot();
    int cand[$];
    for (int i = 0; i < NS; i++) if (m_out[i]) cand.push_back(i);
    if (cand.size() != 0 && ($urandom % 4) != 0)
      return 2'(cand[$urandom % cand.size()]);
    return 2'($urandom % NS);
  endfunction

  task automatic model_step(input bit r, input bit st, input bit rv, input logic [7:0] rid,
                            input bit tv, input logic [1:0] ts, input bit tl);
    int   adm;
    int   pick;
    bit   rhit;
    iss_t e;
    if (!r) begin
      for (int i = 0; i < NS; i++) begin
        m_used[i] = 0; m_out[i] = 0; m_started[i] = 0;
      end
      m_rr = 0;
      return;
    end
    adm = -1;
    if (rv) begin
      for (int i = NS - 1; i >= 0; i--) if (!m_used[i]) adm = i;
    end
    if (!st) begin
      rhit = tv && m_used[ts] && m_out[ts];
      pick = -1;
      for (int k = 0; k < NS; k++) begin
        int s;
        s = (m_rr + k) % NS;
        if (pick < 0 && m_used[s] && !m_out[s]) pick = s;
      end
      if (pick >= 0) begin
        e.st   = m_started[pick] ? RUN : INI;
        e.slot = 2'(pick);
        e.rd   = m_id[pick];
        iss_q.push_back(e);
        m_out[pick]     = 1;
        m_started[pick] = 1;
        m_rr            = (pick + 1) % NS;
      end
      if (rhit) begin
        if (tl) begin
          done_q.push_back(m_id[ts]);
          m_used[ts] = 0;
        end
        m_out[ts] = 0;
      end
    end
    if (adm >= 0) begin
      m_used[adm]    = 1;
      m_out[adm]     = 0;
      m_started[adm] = 0;
      m_id[adm]      = rid;
    end
  endtask

  task automatic cyc(input bit r, input bit st, input bit rv, input logic [7:0] rid,
                     input bit tv, input logic [1:0] ts, input bit tl);
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(m_any_free()));
    check("busy", 32'(busy), 32'(m_any_used()));
    rst = r; stall = st; req_valid = rv; req_read_num = rid;
    ret_valid = tv; ret_slot = ts; ret_last = tl;
    model_step(r, st, rv, rid, tv, ts, tl);
  endtask

  task automatic idle();
    cyc(1, 0, 0, 8'h00, 0, 2'd0, 0);
  endtask

  // Monitor: compares whatever the DUT presents one step after each active edge.
  logic rst_e, stall_e;
  iss_t last_exp = '0;
  always @(posedge clk) begin
    iss_t got;
    iss_t exp;
    rst_e   = rst;
    stall_e = stall;
    #1;
    got = {issue_status, issue_slot, issue_read};
    if (!rst_e) begin
      check("reset_issue", 32'(got), 32'd0);
      check("reset_done", 32'(done_valid), 32'd0);
      last_exp = '0;
    end else if (stall_e) begin
      check("stall_hold", 32'(got), 32'(last_exp));
    end else if (issue_status == 6'd0) begin
      check("bubble_fields", 32'({issue_slot, issue_read}), 32'd0);
      last_exp = '0;
    end else if (iss_q.size() == 0) begin
      vectors++; errors++;
      $display("FAIL issue_unexpected: got %0h expected none at %0t", got, $time);
    end else begin
      exp = iss_q.pop_front();
      check("issue", 32'(got), 32'(exp));
      last_exp = exp;
    end
    if (rst_e && done_valid) begin
      if (done_q.size() == 0) begin
        vectors++; errors++;
        $display("FAIL done_unexpected: got read %0h expected none at %0t", done_read, $time);
      end else begin
        check("done_read", 32'(done_read), 32'(done_q.pop_front()));
      end
    end
  end

  initial begin
    for (int i = 0; i < NS; i++) begin
      m_used[i] = 0; m_out[i] = 0; m_started[i] = 0; m_id[i] = '0;
    end
    repeat (2) cyc(0, 0, 0, 8'h00, 0, 2'd0, 0);

    // single read through INI, RUN, retire
    cyc(1, 0, 1, 8'h05, 0, 2'd0, 0);
    idle();
    cyc(1, 0, 0, 8'h00, 1, 2'd0, 0);
    idle();
    cyc(1, 0, 0, 8'h00, 1, 2'd0, 1);
    idle();

    // fill all four slots, hold a fifth request until a retire frees slot 1
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 8'(8'h10 + i), 0, 2'd0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 8'h14, 0, 2'd0, 0);
    cyc(1, 0, 1, 8'h14, 1, 2'd1, 1);
    cyc(1, 0, 1, 8'h14, 0, 2'd0, 0);
    idle();

    // slots 2 and 0 return non-last, then a long stall with returns and an admission
    cyc(1, 0, 0, 8'h00, 1, 2'd2, 0);
    cyc(1, 0, 0, 8'h00, 1, 2'd0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, (i == 2), 8'h22, 1, 2'(i % NS), 1);
    repeat (3) idle();

    // reset mid-flight, then a stale return on slot 0
    repeat (3) cyc(0, 0, 0, 8'h00, 1, 2'd0, 1);
    cyc(1, 0, 0, 8'h00, 1, 2'd0, 1);
    idle();

    // ignored return on a free slot; retire of slot 0 alongside an admission
    cyc(1, 0, 1, 8'hA0, 1, 2'd2, 1);
    idle();
    cyc(1, 0, 1, 8'hA1, 1, 2'd0, 1);
    idle();
    cyc(1, 0, 0, 8'h00, 1, 2'd1, 1);
    idle();

    for (int n = 0; n < 3000; n++) begin
      bit st, rv, tv, tl;
      st = ($urandom % 6) == 0;
      rv = ($urandom % 3) == 0;
      tv = ($urandom % 2) == 0;
      tl = ($urandom % 3) == 0;
      if (n == 1500) repeat (3) cyc(0, 0, 0, 8'h00, 0, 2'd0, 0);
      cyc(1, st, rv, 8'($urandom), tv, pick_ret_slot(), tl);
    end

    for (int n = 0; n < 400 && m_any_used(); n++) begin
      logic [1:0] s;
      s = pick_ret_slot();
      cyc(1, 0, 0, 8'h00, m_out[s], s, 1);
    end
    repeat (3) idle();
    @(posedge clk);
    #2;
    check("issue_queue_drained", 32'(iss_q.size()), 32'd0);
    check("done_queue_drained", 32'(done_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
